// File: rtl/reg_file_mp.sv
// Multi-ported register file with registered reads, a priority write merge,
// an optional hard-wired zero entry and a post-reset clear sweep.
module reg_file_mp #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_READ   = 2,
   parameter int NUM_WRITE  = 2,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
   input  logic [NUM_WRITE-1:0]             wr_en,
   input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  wr_addr,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wr_data,
   output logic                             busy
);

   localparam int CAP = 1 << ADDR_WIDTH;

   typedef enum logic {ST_CLEAR, ST_READY} state_e;

   state_e                          state_q, state_d;
   logic [ADDR_WIDTH-1:0]           clr_cnt_q, clr_cnt_d;
   logic                            busy_q, busy_d;
   logic [NUM_READ*DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
   logic [DATA_WIDTH-1:0]           mem_q [CAP];
   logic [NUM_WRITE-1:0]            wr_keep;
   logic [ADDR_WIDTH-1:0]           ra;
   logic [DATA_WIDTH-1:0]           rv;

   // Writes aimed at the hard-wired zero entry are dropped before they can
   // reach either the storage or the bypass path.
   always_comb begin
      wr_keep = '0;
      for (int j = 0; j < NUM_WRITE; j++) begin
         wr_keep[j] = wr_en[j] &&
                      !((ZERO_REG != 0) && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == '0));
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      busy_d    = busy_q;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            busy_d    = 1'b1;
            if (clr_cnt_q == '1) begin
               state_d = ST_READY;
               busy_d  = 1'b0;
            end
         end
         ST_READY: busy_d = 1'b0;
         default: begin
            state_d = ST_CLEAR;
            busy_d  = 1'b1;
         end
      endcase
   end

   // Ascending port order lets the highest-index matching writer win the bypass.
   always_comb begin
      rd_data_d = '0;
      ra        = '0;
      rv        = '0;
      if (state_q == ST_READY) begin
         for (int i = 0; i < NUM_READ; i++) begin
            ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            rv = mem_q[ra];
            if (BYPASS != 0) begin
               for (int j = 0; j < NUM_WRITE; j++) begin
                  if (wr_keep[j] && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra))
                     rv = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
               end
            end
            if ((ZERO_REG != 0) && (ra == '0))
               rv = '0;
            rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = rv;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage keeps its contents on a reset edge; later NBAs override earlier
   // ones, so the highest-index port wins a write-write conflict.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state_q == ST_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
         end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
               if (wr_keep[j])
                  mem_q[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   assign rd_data = rd_data_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a write-first/zero-reg instance and a
// read-first/no-zero-reg instance share stimulus and are checked every cycle.
module tb_reg_file_mp;

   localparam int AW  = 5;
   localparam int DW  = 32;
   localparam int NR  = 3;
   localparam int NW  = 2;
   localparam int CAP = 1 << AW;

   logic                clock;
   logic                reset;
   logic [NR*AW-1:0]    rd_addr;
   logic [NW-1:0]       wr_en;
   logic [NW*AW-1:0]    wr_addr;
   logic [NW*DW-1:0]    wr_data;
   logic [NR*DW-1:0]    rd_data_wf, rd_data_rf;
   logic                busy_wf, busy_rf;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] m_wf [CAP];
   logic [DW-1:0] m_rf [CAP];
   logic          m_busy;
   int            m_cnt;

   logic [NR*DW-1:0] q_wf [$];
   logic [NR*DW-1:0] q_rf [$];
   logic             q_busy [$];

   reg_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW),
                 .ZERO_REG(1), .BYPASS(1)) dut_wf (
      .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_wf),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy_wf));

   reg_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW),
                 .ZERO_REG(0), .BYPASS(0)) dut_rf (
      .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_rf),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy_rf));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Predict this edge's outputs, push them, advance the model, clock, then compare.
   task automatic step(input string tag);
      logic [NR*DW-1:0] e_wf, e_rf;
      logic             e_busy;
      logic [AW-1:0]    a, wa;
      logic [DW-1:0]    v;
      e_wf = '0;
      e_rf = '0;
      if (!reset && !m_busy) begin
         for (int i = 0; i < NR; i++) begin
            a = rd_addr[i*AW +: AW];
            v = m_wf[a];
            for (int j = 0; j < NW; j++)
               if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*DW +: DW];
            if (a == 0) v = '0;
            e_wf[i*DW +: DW] = v;
            e_rf[i*DW +: DW] = m_rf[a];
         end
      end
      if (reset)       e_busy = 1'b1;
      else if (m_busy) e_busy = (m_cnt != CAP - 1);
      else             e_busy = 1'b0;
      q_wf.push_back(e_wf);
      q_rf.push_back(e_rf);
      q_busy.push_back(e_busy);

      if (reset) begin
         m_busy = 1'b1;
         m_cnt  = 0;
      end else if (m_busy) begin
         m_wf[m_cnt] = '0;
         m_rf[m_cnt] = '0;
         if (m_cnt == CAP - 1) m_busy = 1'b0;
         m_cnt++;
      end else begin
         for (int j = 0; j < NW; j++) begin
            if (wr_en[j]) begin
               wa = wr_addr[j*AW +: AW];
               m_rf[wa] = wr_data[j*DW +: DW];
               if (wa != 0) m_wf[wa] = wr_data[j*DW +: DW];
            end
         end
      end

      @(posedge clock);
      #1;
      chk({tag, ".rd_wf"}, 128'(rd_data_wf), 128'(q_wf.pop_front()));
      chk({tag, ".rd_rf"}, 128'(rd_data_rf), 128'(q_rf.pop_front()));
      e_busy = q_busy.pop_front();
      chk({tag, ".busy_wf"}, 128'(busy_wf), 128'(e_busy));
      chk({tag, ".busy_rf"}, 128'(busy_rf), 128'(e_busy));
   endtask

   task automatic idle();
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
   endtask

   // Runs the sweep with 0xAA writes offered every cycle; returns busy-high count.
   task automatic sweep(output int n);
      n = 0;
      for (int k = 0; k < CAP + 8; k++) begin
         if (!busy_wf) break;
         n++;
         wr_en   = 2'b11;
         wr_addr = {5'd4, 5'd2};
         wr_data = {32'hAA, 32'hAA};
         rd_addr = {5'd4, 5'd2, 5'd1};
         step("sweep");
      end
      idle();
   endtask

   initial begin
      int n;
      m_busy = 1'b0;
      m_cnt  = 0;
      reset  = 1'b1;
      idle();
      @(negedge clock);

      step("reset");
      reset = 1'b0;
      sweep(n);
      chk("busy_len", 128'(n), 128'(CAP));

      for (int a = 0; a < CAP; a += NR) begin
         for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = AW'((a + i) % CAP);
         step("clear_read");
      end

      idle();
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd3};
      wr_data = {32'h0, 32'h1234};
      rd_addr = {5'd0, 5'd0, 5'd3};
      step("bypass_wr");
      idle();
      rd_addr = {5'd0, 5'd0, 5'd3};
      step("bypass_after");

      wr_en   = 2'b11;
      wr_addr = {5'd7, 5'd7};
      wr_data = {32'h22, 32'h11};
      rd_addr = {5'd0, 5'd7, 5'd7};
      step("conflict_wr");
      idle();
      rd_addr = {5'd7, 5'd7, 5'd7};
      step("conflict_after");

      wr_en   = 2'b11;
      wr_addr = {5'd0, 5'd0};
      wr_data = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
      rd_addr = {5'd0, 5'd0, 5'd0};
      step("zero_wr");
      idle();
      step("zero_after");

      reset = 1'b1;
      step("reset2");
      reset = 1'b0;
      for (int k = 0; k < 10; k++) step("partial_sweep");
      reset = 1'b1;
      step("reset_mid");
      reset = 1'b0;
      sweep(n);
      chk("busy_len_restart", 128'(n), 128'(CAP));
      rd_addr = {5'd7, 5'd3, 5'd0};
      step("restart_read");

      for (int c = 0; c < 10000; c++) begin
         wr_en = NW'($urandom_range(0, 3));
         for (int j = 0; j < NW; j++) begin
            wr_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
            wr_data[j*DW +: DW] = $urandom;
         end
         for (int i = 0; i < NR; i++)
            rd_addr[i*AW +: AW] = (c % 4 == 0) ? AW'($urandom_range(0, CAP - 1))
                                               : AW'($urandom_range(0, 7));
         step("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
